// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the RV32I memory subsystem.
package rv32i_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_t;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/rv32i_starve_counter.sv
// Saturating wait counter: clear wins over increment, holds at LIMIT.
module rv32i_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_cnt,
    output logic       o_at_limit
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch (I) and the data path (D),
// with D priority bounded by an I starvation counter.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [29:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output mem_owner_t  o_dbg_owner,
    output logic [3:0]  o_dbg_starve_cnt
);

    // Handshake: a requester holds req and its inputs until it sees gnt in the
    // same cycle; read data follows exactly one cycle later, flagged by rvalid.
    // Dropping req before gnt is allowed and leaves no state behind.

    mem_owner_t  r_owner;
    logic [29:0] r_ram_addr;
    logic [31:0] r_ram_wdata;
    logic        w_at_limit;
    logic        w_i_win;
    logic [3:0]  w_starve_cnt;

    rv32i_starve_counter #(.LIMIT(STARVE_MAX)) u_i_starve (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (i_gnt || !i_req),
        .i_inc      (i_req && !i_gnt),
        .o_cnt      (w_starve_cnt),
        .o_at_limit (w_at_limit)
    );

    assign w_i_win = i_req && !reset && (!d_req || w_at_limit);
    assign i_gnt   = w_i_win;
    assign d_gnt   = d_req && !reset && !w_i_win;
    assign i_stall = i_req && !i_gnt;
    assign d_stall = d_req && !d_gnt;

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_addr  = r_ram_addr;
        ram_wdata = r_ram_wdata;
        if (d_gnt) begin
            ram_we    = d_we;
            ram_be    = d_be;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (i_gnt) begin
            ram_addr  = i_addr;
        end
    end

    // Stores never claim the response slot, so no rvalid follows them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= OWN_NONE;
            r_ram_addr  <= 30'd0;
            r_ram_wdata <= 32'd0;
        end else begin
            r_ram_addr  <= ram_addr;
            r_ram_wdata <= ram_wdata;
            if (i_gnt) begin
                r_owner <= OWN_I;
            end else if (d_gnt && !d_we) begin
                r_owner <= OWN_D;
            end else begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign i_rvalid = (r_owner == OWN_I) && !reset;
    assign d_rvalid = (r_owner == OWN_D) && !reset;
    assign i_rdata  = ram_rdata;
    assign d_rdata  = ram_rdata;

    assign o_dbg_owner      = r_owner;
    assign o_dbg_starve_cnt = w_starve_cnt;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_rv32i_mem_arbiter;
    import rv32i_pkg::*;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [29:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [29:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    mem_owner_t  dbg_owner;
    logic [3:0]  dbg_cnt;

    int tests_run;
    int tests_failed;

    rv32i_mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_req            (i_req),
        .i_addr           (i_addr),
        .i_gnt            (i_gnt),
        .i_rvalid         (i_rvalid),
        .i_rdata          (i_rdata),
        .i_stall          (i_stall),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_be             (d_be),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_gnt            (d_gnt),
        .d_rvalid         (d_rvalid),
        .d_rdata          (d_rdata),
        .d_stall          (d_stall),
        .ram_we           (ram_we),
        .ram_be           (ram_be),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .o_dbg_owner      (dbg_owner),
        .o_dbg_starve_cnt (dbg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word i initialised to 32'hA000_0000 | i on the first edge.
    logic [31:0] mem [0:1023];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | i;
            mem_ready <= 1'b1;
        end else begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr[9:0]];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = 30'd0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'd0; d_addr = 30'd0; d_wdata = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_req = 1'b1; i_addr = 30'h10;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 30'h50; d_wdata = 32'h1234_5678;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if ({i_gnt, d_gnt, ram_we, ram_be, i_rvalid, d_rvalid} !== 9'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs: gnt/we/be/rvalid = %b, required 0",
                         {i_gnt, d_gnt, ram_we, ram_be, i_rvalid, d_rvalid});
            end
            cyc();
        end
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({dbg_owner, dbg_cnt, i_rvalid, d_rvalid} !== {OWN_NONE, 4'd0, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset_state: owner=%0d cnt=%0d rvalid=%b%b, required 0 0 00",
                     dbg_owner, dbg_cnt, i_rvalid, d_rvalid);
        end
        cyc();
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 30'h10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({i_gnt, i_stall, d_gnt, ram_we, ram_be, ram_addr} !== {4'b1000, 4'd0, 30'h10}) begin
                tests_failed++;
                $display("FAIL fetch_grant[%0d]: gnt/stall/dgnt/we=%b be=%h addr=%h, required 1000 0 10",
                         k, {i_gnt, i_stall, d_gnt, ram_we}, ram_be, ram_addr);
            end
            if (k > 0) begin
                tests_run++;
                if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'hA000_0010}) begin
                    tests_failed++;
                    $display("FAIL fetch_data[%0d]: rvalid=%b%b data=%h, required 10 a0000010",
                             k, i_rvalid, d_rvalid, i_rdata);
                end
            end
            cyc();
        end
        i_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({i_gnt, i_rvalid, i_rdata} !== {2'b01, 32'hA000_0010}) begin
            tests_failed++;
            $display("FAIL fetch_tail: gnt=%b rvalid=%b data=%h, required 0 1 a0000010",
                     i_gnt, i_rvalid, i_rdata);
        end
        cyc();
    endtask

    task automatic test_contend();
        i_req = 1'b1; i_addr = 30'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h200;
        @(negedge clk);
        tests_run++;
        if ({d_gnt, i_gnt, i_stall, d_stall, ram_we, ram_addr} !== {5'b10100, 30'h200}) begin
            tests_failed++;
            $display("FAIL contend_grant: dgnt/ignt/istall/dstall/we=%b addr=%h, required 10100 200",
                     {d_gnt, i_gnt, i_stall, d_stall, ram_we}, ram_addr);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if ({d_rvalid, i_rvalid, d_rdata} !== {2'b10, 32'hA000_0200}) begin
            tests_failed++;
            $display("FAIL contend_data: drvalid/irvalid=%b%b data=%h, required 10 a0000200",
                     d_rvalid, i_rvalid, d_rdata);
        end
        cyc();
    endtask

    task automatic test_store_be();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 30'h100; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if ({d_gnt, ram_we, ram_be, ram_wdata} !== {2'b11, 4'b0011, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL store_drive: gnt/we=%b be=%b wdata=%h, required 11 0011 deadbeef",
                     {d_gnt, ram_we}, ram_be, ram_wdata);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (d_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_no_rvalid: d_rvalid=%b, required 0", d_rvalid);
        end
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h100;
        @(negedge clk);
        tests_run++;
        if ({d_gnt, ram_we} !== 2'b10) begin
            tests_failed++;
            $display("FAIL store_readback_grant: gnt/we=%b, required 10", {d_gnt, ram_we});
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hA000_BEEF}) begin
            tests_failed++;
            $display("FAIL store_readback: rvalid=%b data=%h, required 1 a000beef", d_rvalid, d_rdata);
        end
        cyc();
    endtask

    task automatic test_starve();
        logic exp_i;
        logic [3:0] exp_cnt;
        i_req = 1'b1; i_addr = 30'h20;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 30'h300; d_wdata = 32'h5555_AAAA;
        for (int c = 1; c <= 10; c++) begin
            exp_i   = (c == 5) || (c == 10);
            exp_cnt = 4'((c - 1) % 5);
            @(negedge clk);
            tests_run++;
            if ({i_gnt, d_gnt, ram_we, i_stall, dbg_cnt} !== {exp_i, !exp_i, !exp_i, !exp_i, exp_cnt}) begin
                tests_failed++;
                $display("FAIL starve[%0d]: ignt/dgnt/we/istall=%b cnt=%0d, required %b cnt=%0d",
                         c, {i_gnt, d_gnt, ram_we, i_stall}, dbg_cnt,
                         {exp_i, !exp_i, !exp_i, !exp_i}, exp_cnt);
            end
            cyc();
        end
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'hA000_0020}) begin
            tests_failed++;
            $display("FAIL starve_fetch_data: rvalid=%b data=%h, required 1 a0000020", i_rvalid, i_rdata);
        end
        cyc();
    endtask

    task automatic test_drop();
        i_req = 1'b1; i_addr = 30'h30;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 30'h301; d_wdata = 32'd0;
        cyc();
        cyc();
        i_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({dbg_cnt, d_gnt, i_stall} !== {4'd2, 2'b10}) begin
            tests_failed++;
            $display("FAIL drop_before: cnt=%0d dgnt/istall=%b%b, required 2 10", dbg_cnt, d_gnt, i_stall);
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (dbg_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL drop_clears: cnt=%0d, required 0", dbg_cnt);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h200;
        @(negedge clk);
        tests_run++;
        if (d_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_grant: d_gnt=%b, required 1", d_gnt);
        end
        cyc();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({d_rvalid, i_rvalid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rstmid_rvalid: rvalid=%b%b, required 00", d_rvalid, i_rvalid);
        end
        cyc();
        reset = 1'b0;
        i_req = 1'b1; i_addr = 30'h10;
        @(negedge clk);
        tests_run++;
        if ({dbg_owner, dbg_cnt, d_rvalid, i_gnt} !== {OWN_NONE, 4'd0, 2'b01}) begin
            tests_failed++;
            $display("FAIL rstmid_after: owner=%0d cnt=%0d drvalid=%b igntt=%b, required 0 0 0 1",
                     dbg_owner, dbg_cnt, d_rvalid, i_gnt);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'hA000_0010}) begin
            tests_failed++;
            $display("FAIL rstmid_fetch: rvalid=%b data=%h, required 1 a0000010", i_rvalid, i_rdata);
        end
        cyc();
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if ({ram_we, ram_be, i_gnt, d_gnt, i_rvalid, d_rvalid, dbg_cnt} !== 13'd0) begin
                tests_failed++;
                $display("FAIL idle[%0d]: we=%b be=%b gnt=%b%b rvalid=%b%b cnt=%0d, required all 0",
                         k, ram_we, ram_be, i_gnt, d_gnt, i_rvalid, d_rvalid, dbg_cnt);
            end
            cyc();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fetch();
        test_contend();
        test_store_be();
        test_starve();
        test_drop();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
